// File: rtl/cache_def_pipe_data.sv
// Shared cache pipeline definitions: default geometry, tag entry layout and
// the tag-array sweep state encoding.
package cache_def_pipe_data;

  localparam int CACHE_WAYS    = 4;
  localparam int CACHE_SET_NUM = 128;
  localparam int CACHE_TAG_W   = 20;

  // Entry layout is {valid, dirty, tag}, valid in the MSB.
  function automatic int entry_w(input int tag_w);
    return tag_w + 2;
  endfunction

  function automatic int entry_vld_bit(input int tag_w);
    return tag_w + 1;
  endfunction

  function automatic int entry_dirty_bit(input int tag_w);
    return tag_w;
  endfunction

  typedef struct packed {
    logic                   valid;
    logic                   dirty;
    logic [CACHE_TAG_W-1:0] tag;
  } cache_tag_entry_t;

  typedef enum logic {
    INIT,
    IDLE
  } tag_arr_state_e;

endpackage

// File: rtl/cache_tag_way_ram.sv
// One way of tag storage: DEPTH x WIDTH inferred RAM, synchronous read-first,
// separate write and read addresses so a lookup and an update can share a cycle.
module cache_tag_way_ram #(
  parameter  int DEPTH = 128,
  parameter  int WIDTH = 22,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cache_tag_array.sv
// N-way tag store with registered per-way hit lookup and a hardware
// invalidate sweep after reset and on flush.
//
//   state | meaning
//   INIT  | sweep: clear every way at index = sweep_cnt, busy=1
//   IDLE  | lookups and updates accepted; flush_req restarts the sweep
module cache_tag_array
  import cache_def_pipe_data::*;
#(
  parameter  int WAYS    = CACHE_WAYS,
  parameter  int SET_NUM = CACHE_SET_NUM,
  parameter  int TAG_W   = CACHE_TAG_W,
  localparam int IDX_W   = $clog2(SET_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_req,
  output logic                  busy,
  input  logic                  lk_valid,
  input  logic [IDX_W-1:0]      lk_index,
  input  logic [TAG_W-1:0]      lk_tag,
  output logic                  lk_ready,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [WAYS-1:0]       rsp_hit_way,
  output logic [WAYS-1:0]       rsp_dirty,
  output logic [WAYS-1:0]       rsp_valid_bits,
  output logic [WAYS*TAG_W-1:0] rsp_tags,
  input  logic                  wr_en,
  input  logic [WAYS-1:0]       wr_way,
  input  logic [IDX_W-1:0]      wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic                  wr_vld,
  input  logic                  wr_dirty
);

  localparam int EW    = entry_w(TAG_W);
  localparam int VLD_B = entry_vld_bit(TAG_W);
  localparam int DRT_B = entry_dirty_bit(TAG_W);

  tag_arr_state_e   state, state_nxt;
  logic [IDX_W-1:0] sweep_cnt, sweep_cnt_nxt;
  logic             sweeping;
  logic             lk_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    sweeping      = 1'b0;
    case (state)
      INIT: begin
        sweeping      = 1'b1;
        sweep_cnt_nxt = sweep_cnt + IDX_W'(1);
        if (sweep_cnt == IDX_W'(SET_NUM - 1)) begin
          state_nxt     = IDLE;
          sweep_cnt_nxt = '0;
        end
      end
      IDLE: begin
        if (flush_req) begin
          state_nxt     = INIT;
          sweep_cnt_nxt = '0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign busy      = sweeping;
  assign lk_ready  = ~sweeping;
  assign lk_accept = lk_valid & ~sweeping;

  // The sweep owns the write port outright; controller updates are dropped.
  logic [IDX_W-1:0] ram_waddr;
  logic [EW-1:0]    ram_wdata;

  assign ram_waddr = sweeping ? sweep_cnt : wr_index;
  assign ram_wdata = sweeping ? '0 : {wr_vld, wr_dirty, wr_tag};

  logic [TAG_W-1:0]      cmp_tag;
  logic [EW-1:0]         rd_entry [WAYS];
  logic [WAYS-1:0]       live_hit, live_dirty, live_vbits;
  logic [WAYS*TAG_W-1:0] live_tags;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic way_we;

    assign way_we = sweeping | (wr_en & wr_way[w]);

    cache_tag_way_ram #(
      .DEPTH (SET_NUM),
      .WIDTH (EW)
    ) u_ram (
      .clk   (clk),
      .we    (way_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (lk_index),
      .rdata (rd_entry[w])
    );

    assign live_vbits[w]                = rd_entry[w][VLD_B];
    assign live_dirty[w]                = rd_entry[w][DRT_B];
    assign live_tags[w*TAG_W +: TAG_W]  = rd_entry[w][TAG_W-1:0];
    assign live_hit[w]                  = rd_entry[w][VLD_B] &
                                          (rd_entry[w][TAG_W-1:0] == cmp_tag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      cmp_tag   <= '0;
    end else begin
      rsp_valid <= lk_accept;
      if (lk_accept) cmp_tag <= lk_tag;
    end
  end

  // The RAM output follows lk_index every cycle, so the last valid response
  // is captured here and replayed while rsp_valid is low.
  logic [WAYS-1:0]       hold_hit, hold_dirty, hold_vbits;
  logic [WAYS*TAG_W-1:0] hold_tags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_hit   <= '0;
      hold_dirty <= '0;
      hold_vbits <= '0;
      hold_tags  <= '0;
    end else if (rsp_valid) begin
      hold_hit   <= live_hit;
      hold_dirty <= live_dirty;
      hold_vbits <= live_vbits;
      hold_tags  <= live_tags;
    end
  end

  assign rsp_hit_way    = rsp_valid ? live_hit   : hold_hit;
  assign rsp_dirty      = rsp_valid ? live_dirty : hold_dirty;
  assign rsp_valid_bits = rsp_valid ? live_vbits : hold_vbits;
  assign rsp_tags       = rsp_valid ? live_tags  : hold_tags;
  assign rsp_hit        = |rsp_hit_way;

endmodule
